token_merge_arb: RTL and testbench

Two-input token merge arbiter placed in front of the Dec0 decode stage. Two upstream fetch channels share the single decode datapath. The block accepts one token at a time over a four-phase send/ack handshake, picks between simultaneous requests round-robin, holds the token in a one-entry buffer, and presents it downstream over a four-phase send/ack handshake. The token is 127 bits: node 16, gen 12, opr0 32, opr1 32, mem_wen 1, ins 34.

---
 rtl/token_merge_arb_pkg.sv | 43 ++++
 rtl/token_merge_arb_if.sv | 28 ++
 rtl/token_merge_arb_rr_arb2.sv | 14 +
 rtl/token_merge_arb.sv | 125 ++++++++++++
 tb/tb_token_merge_arb.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/token_merge_arb_pkg.sv
// cues_token_pkg: shared definitions for the token merge arbiter.
//   - token field widths and bit offsets (ins at LSB, node at MSB)
//   - TOK_W, the packed token width (127)
//   - state encodings for the input (capture) and output (send) FSMs
package cues_token_pkg;

  localparam int NODE_W   = 16;
  localparam int GEN_W    = 12;
  localparam int OPR_W    = 32;
  localparam int MEMWEN_W = 1;
  localparam int INS_W    = 34;

  localparam int INS_LSB    = 0;
  localparam int MEMWEN_LSB = INS_LSB + INS_W;
  localparam int OPR1_LSB   = MEMWEN_LSB + MEMWEN_W;
  localparam int OPR0_LSB   = OPR1_LSB + OPR_W;
  localparam int GEN_LSB    = OPR0_LSB + OPR_W;
  localparam int NODE_LSB   = GEN_LSB + GEN_W;
  localparam int TOK_W      = NODE_LSB + NODE_W;

  // Declaration order gives node at the MSB and ins at the LSB.
  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr0;
    logic [OPR_W-1:0]  opr1;
    logic              mem_wen;
    logic [INS_W-1:0]  ins;
  } tok_t;

  typedef enum logic {IN_IDLE, IN_ACK} in_st_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SEND, OUT_WAIT} out_st_e;

  function automatic logic [TOK_W-1:0] pack_tok(
    input logic [NODE_W-1:0] node, input logic [GEN_W-1:0] gen,
    input logic [OPR_W-1:0] opr0, input logic [OPR_W-1:0] opr1,
    input logic mem_wen, input logic [INS_W-1:0] ins);
    tok_t t;
    t = '{node: node, gen: gen, opr0: opr0, opr1: opr1, mem_wen: mem_wen, ins: ins};
    return t;
  endfunction

endpackage

// File: rtl/token_merge_arb_if.sv
// token_merge_arb_if: handshake bundle around the merge arbiter.
//   upstream  : send0_i/send1_i, tok0_i/tok1_i -> arbiter, ack0_o/ack1_o back
//   downstream: send_o, tok_o -> Dec0, ack_i back
//   stats     : cnt0_o/cnt1_o accepted-token counters
// Signal suffixes are from the arbiter's point of view.
// slave modport = arbiter side, master modport = partner (fetch/Dec0) side.
interface token_merge_arb_if #(
  parameter int TOK_W = cues_token_pkg::TOK_W,
  parameter int CNT_W = 16
);
  logic             send0_i, send1_i;
  logic [TOK_W-1:0] tok0_i, tok1_i;
  logic             ack0_o, ack1_o;
  logic             send_o;
  logic [TOK_W-1:0] tok_o;
  logic             ack_i;
  logic [CNT_W-1:0] cnt0_o, cnt1_o;

  modport slave (
    input  send0_i, send1_i, tok0_i, tok1_i, ack_i,
    output ack0_o, ack1_o, send_o, tok_o, cnt0_o, cnt1_o
  );

  modport master (
    output send0_i, send1_i, tok0_i, tok1_i, ack_i,
    input  ack0_o, ack1_o, send_o, tok_o, cnt0_o, cnt1_o
  );
endinterface

// File: rtl/token_merge_arb_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin select.
//   req_i  : request per input
//   last_i : most recently granted input
//   win_o  : winner index (sole requester, or the input != last_i on a tie)
//   vld_o  : at least one request present
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       win_o,
  output logic       vld_o
);
  assign vld_o = |req_i;
  assign win_o = (&req_i) ? ~last_i : req_i[1];
endmodule

// File: rtl/token_merge_arb.sv
// token_merge_arb: merges two four-phase token streams into one for Dec0.
//   clk    : clock, all state on rising edge
//   rst    : synchronous active-low reset
//   lopen  : stage enable, low blocks new captures only
//   bus    : token_merge_arb_if.slave (upstream x2 + downstream handshakes, counters)
// One-entry buffer (tok_q/full_q). The input FSM captures into it, the output
// FSM drains it; the two only meet through full_q, so a slot freed at an edge
// is refillable from the following edge.
// Optional: define TOKEN_MERGE_STAT_EN to build saturating per-input
// accepted-token counters; otherwise cnt0_o/cnt1_o are tied to 0.
module token_merge_arb #(
  parameter int TOK_W = cues_token_pkg::TOK_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lopen,
  token_merge_arb_if.slave bus
);
  import cues_token_pkg::*;

  in_st_e           in_st_q, in_st_d;
  out_st_e          out_st_q, out_st_d;
  logic             full_q, full_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;   // input currently being acknowledged
  logic [TOK_W-1:0] tok_q, tok_d;
  logic             win, win_vld, cap;

  rr_arb2 u_arb (
    .req_i  ({bus.send1_i, bus.send0_i}),
    .last_i (last_q),
    .win_o  (win),
    .vld_o  (win_vld)
  );

  // Capture uses the registered full flag only.
  assign cap = (in_st_q == IN_IDLE) && !full_q && lopen && win_vld;

  always_comb begin
    in_st_d = in_st_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    tok_d   = tok_q;
    case (in_st_q)
      IN_IDLE: if (cap) begin
        in_st_d = IN_ACK;
        gnt_d   = win;
        last_d  = win;
        tok_d   = win ? bus.tok1_i : bus.tok0_i;
      end
      IN_ACK: if (!(gnt_q ? bus.send1_i : bus.send0_i)) in_st_d = IN_IDLE;
      default: in_st_d = IN_IDLE;
    endcase
  end

  // cap needs full_q=0 while the clear happens in OUT_SEND (full_q=1),
  // so the set and clear below never collide.
  always_comb begin
    out_st_d = out_st_q;
    full_d   = full_q;
    if (cap) full_d = 1'b1;
    case (out_st_q)
      OUT_IDLE: if (full_q) out_st_d = OUT_SEND;
      OUT_SEND: if (bus.ack_i) begin
        out_st_d = OUT_WAIT;
        full_d   = 1'b0;
      end
      OUT_WAIT: if (!bus.ack_i) out_st_d = OUT_IDLE;
      default:  out_st_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_st_q  <= IN_IDLE;
      out_st_q <= OUT_IDLE;
      full_q   <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      tok_q    <= '0;
    end else begin
      in_st_q  <= in_st_d;
      out_st_q <= out_st_d;
      full_q   <= full_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      tok_q    <= tok_d;
    end
  end

  assign bus.ack0_o = (in_st_q == IN_ACK) && !gnt_q;
  assign bus.ack1_o = (in_st_q == IN_ACK) &&  gnt_q;
  assign bus.send_o = (out_st_q == OUT_SEND);
  assign bus.tok_o  = tok_q;

`ifdef TOKEN_MERGE_STAT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating increment: hold at all-ones instead of wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cap && !win && !(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
    if (cap &&  win && !(&cnt1_q)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0_o = cnt0_q;
  assign bus.cnt1_o = cnt1_q;
`else
  assign bus.cnt0_o = {CNT_W{1'b0}};
  assign bus.cnt1_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_token_merge_arb.sv
module tb_token_merge_arb;
  import cues_token_pkg::*;

  localparam int TW   = TOK_W;
  localparam int CW   = 4;
  localparam int CMAX = 15;
`ifdef TOKEN_MERGE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lopen = 1'b1;

  token_merge_arb_if #(.TOK_W(TW), .CNT_W(CW)) bus ();
  token_merge_arb #(.TOK_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .lopen(lopen), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: tokens accepted but not yet delivered, grant log,
  // expected last grant, accepted counts, and partner agent knobs.
  logic [TW-1:0] mq[$];
  int            grants[$];
  int            pend[2];
  int            cnt_m[2];
  int            last_m;
  int            down_mode;  // 0 never ack, 1 ack at once, 2 random delay
  bit            hold_up, rnd_up;
  logic [1:0]    pa;
  logic          prev_so;
  logic [TW-1:0] prev_tok;
  int            target;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] rtok();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[TW-1:0];
  endfunction

  function automatic int exp_cnt(input int i);
    if (!STAT) return 0;
    return (cnt_m[i] > CMAX) ? CMAX : cnt_m[i];
  endfunction

  task automatic set_send(input int i, input logic v, input logic [TW-1:0] t);
    if (i == 0) begin bus.send0_i = v; if (v) bus.tok0_i = t; end
    else        begin bus.send1_i = v; if (v) bus.tok1_i = t; end
  endtask

  task automatic model_reset();
    mq.delete(); grants.delete();
    pend[0] = 0; pend[1] = 0; cnt_m[0] = 0; cnt_m[1] = 0;
    last_m = 1; pa = 2'b00; prev_so = 1'b0; prev_tok = '0;
    hold_up = 1'b0; rnd_up = 1'b0;
    bus.send0_i = 1'b0; bus.send1_i = 1'b0; bus.ack_i = 1'b0;
  endtask

  // One clock: observe after the edge, update the model, then drive partners.
  task automatic cycle();
    logic [1:0] a, s;
    logic so;
    int ew;
    bit go;
    @(posedge clk); #1;
    a  = {bus.ack1_o, bus.ack0_o};
    s  = {bus.send1_i, bus.send0_i};
    so = bus.send_o;
    chk("one_ack", a[0] & a[1], 0);
    if (prev_so && so) chk("tok_stable", bus.tok_o, prev_tok);
    for (int i = 0; i < 2; i++) begin
      if (a[i] && !pa[i]) begin
        if (s == 2'b11) ew = 1 - last_m;
        else if (s[1])  ew = 1;
        else if (s[0])  ew = 0;
        else            ew = 2;
        chk("grant", i, ew);
        last_m = i;
        grants.push_back(i);
        mq.push_back(i == 0 ? bus.tok0_i : bus.tok1_i);
        cnt_m[i]++;
        pend[i]--;
      end
    end
    chk("cnt0", bus.cnt0_o, exp_cnt(0));
    chk("cnt1", bus.cnt1_o, exp_cnt(1));
    for (int i = 0; i < 2; i++) begin
      if (s[i] && a[i] && !hold_up) set_send(i, 1'b0, '0);
      else if (!s[i] && !a[i] && pend[i] > 0 && (!rnd_up || $urandom_range(0, 3) == 0))
        set_send(i, 1'b1, rtok());
    end
    if (so && !bus.ack_i) begin
      go = (down_mode == 1) || (down_mode == 2 && $urandom_range(0, 2) == 0);
      if (go) begin
        if (mq.size() == 0) chk("spurious_send", so, 0);
        else begin
          chk("deliver", bus.tok_o, mq.pop_front());
          bus.ack_i = 1'b1;
        end
      end
    end else if (!so && bus.ack_i) bus.ack_i = 1'b0;
    pa = a; prev_so = so; prev_tok = bus.tok_o;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return bus.ack0_o;
      1: return bus.ack1_o;
      2: return bus.send_o;
      3: return mq.size() == 0 && !bus.send_o && !bus.ack_i && !bus.ack0_o &&
                !bus.ack1_o && pend[0] == 0 && pend[1] == 0 &&
                !bus.send0_i && !bus.send1_i;
      default: return grants.size() >= target;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input int budget);
    int n = 0;
    while (!cond(sel) && n < budget) begin cycle(); n++; end
    chk(tag, cond(sel), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin : main
    logic [TW-1:0] t0, t;
    bit seen;
    bus.tok0_i = '0; bus.tok1_i = '0;
    down_mode = 1;
    do_reset();

    // reset state
    chk("rst_ack0", bus.ack0_o, 0);
    chk("rst_ack1", bus.ack1_o, 0);
    chk("rst_send", bus.send_o, 0);
    chk("rst_tok",  bus.tok_o, 0);
    chk("rst_cnt0", bus.cnt0_o, 0);
    chk("rst_cnt1", bus.cnt1_o, 0);

    // single request with timing
    t0 = pack_tok(16'h1234, 12'h567, 32'h89ab_cdef, 32'h1357_9bdf, 1'b1, 34'h2_0000_00A5);
    down_mode = 0;
    pend[0] = 1;
    set_send(0, 1'b1, t0);
    cycle();
    chk("single_ack_e1",  bus.ack0_o, 1);
    chk("single_send_e1", bus.send_o, 0);
    cycle();
    chk("single_send_e2", bus.send_o, 1);
    chk("single_tok",     bus.tok_o, t0);
    chk("single_ack_fall", bus.ack0_o, 0);
    down_mode = 1;
    cycle();
    cycle();
    chk("single_send_clr", bus.send_o, 0);
    chk("single_cnt0", bus.cnt0_o, STAT ? 1 : 0);
    wait_until("single_idle", 3, 20);

    // tie from reset: alternating grants
    do_reset();
    pend[0] = 2; pend[1] = 2;
    target = 4;
    wait_until("tie_done", 4, 100);
    chk("tie_g0", grants[0], 0);
    chk("tie_g1", grants[1], 1);
    chk("tie_g2", grants[2], 0);
    chk("tie_g3", grants[3], 1);
    wait_until("tie_idle", 3, 50);

    // back-pressure
    down_mode = 0;
    pend[0] = 1;
    wait_until("bp_send", 2, 20);
    t = bus.tok_o;
    pend[1] = 1;
    seen = 0;
    repeat (20) begin cycle(); if (bus.ack1_o) seen = 1; end
    chk("bp_no_ack1", seen, 0);
    chk("bp_tok_hold", bus.tok_o, t);
    down_mode = 1;
    wait_until("bp_ack1", 1, 20);
    wait_until("bp_idle", 3, 50);

    // lopen gating
    lopen = 1'b0;
    pend[0] = 1;
    seen = 0;
    repeat (10) begin cycle(); if (bus.ack0_o) seen = 1; end
    chk("lopen_block", seen, 0);
    lopen = 1'b1;
    cycle();
    chk("lopen_ack_next", bus.ack0_o, 1);
    lopen = 1'b0;
    wait_until("lopen_drop_completes", 3, 30);
    lopen = 1'b1;

    // reset during OUT_SEND with ack0 high
    down_mode = 0;
    hold_up = 1'b1;
    pend[0] = 1;
    wait_until("mid_send", 2, 20);
    chk("mid_ack0", bus.ack0_o, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ack0", bus.ack0_o, 0);
    chk("mid_rst_ack1", bus.ack1_o, 0);
    chk("mid_rst_send", bus.send_o, 0);
    chk("mid_rst_tok",  bus.tok_o, 0);
    chk("mid_rst_cnt0", bus.cnt0_o, 0);
    chk("mid_rst_cnt1", bus.cnt1_o, 0);
    model_reset();
    rst = 1'b1;
    down_mode = 1;
    cycle();
    chk("mid_empty", bus.send_o, 0);
    pend[0] = 1; pend[1] = 1;
    target = 1;
    wait_until("post_rst_tie", 4, 20);
    chk("post_rst_g0", grants[0], 0);
    wait_until("post_rst_idle", 3, 50);

    // saturation
    do_reset();
    pend[1] = 20;
    target = 20;
    wait_until("sat_done", 4, 400);
    wait_until("sat_idle", 3, 50);
    chk("sat_cnt1", bus.cnt1_o, STAT ? 15 : 0);
    chk("sat_cnt0", bus.cnt0_o, 0);

    // randomized traffic against the scoreboard
    do_reset();
    rnd_up = 1'b1;
    down_mode = 2;
    pend[0] = 30; pend[1] = 30;
    repeat (500) begin
      lopen = ($urandom_range(0, 7) != 0);
      cycle();
    end
    lopen = 1'b1;
    down_mode = 1;
    wait_until("rnd_drain", 3, 1000);
    chk("rnd_cnt0", bus.cnt0_o, exp_cnt(0));
    chk("rnd_cnt1", bus.cnt1_o, exp_cnt(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
